// File: rtl/clk_buf_pkg.sv
// Shared types and helpers for the divided-clock bank.
// Ratio width and the zero-to-one ratio mapping live here so every channel agrees.
package clk_buf_pkg;

   localparam int DIV_W_DEF = 8;

   typedef logic [DIV_W_DEF-1:0] div_t;

   typedef enum logic [1:0] {
      CH_IDLE  = 2'd0,
      CH_RUN   = 2'd1,
      CH_DRAIN = 2'd2
   } ch_state_t;

   // A ratio of zero would mean "never toggle"; run it at the fastest rate instead.
   function automatic div_t eff_div(input div_t ratio);
      return (ratio == '0) ? div_t'(1) : ratio;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: half-period counter, glitch-free ratio swap,
// and an enable that always finishes a started high phase.
module clk_div_ch
   import clk_buf_pkg::*;
#(
   parameter div_t RST_DIV = div_t'(1)
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 ch_en,
   input  logic                 load,
   input  logic [DIV_W_DEF-1:0] ratio,
   output logic                 clk_out,
   output logic                 tick,
   output logic                 running
);

   ch_state_t state, state_n;
   div_t      cnt, cnt_n;
   div_t      pending, pending_n;
   div_t      active, active_n;
   div_t      d_eff;
   logic      out_q, out_n;
   logic      tick_q, tick_n;
   logic      term;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state   <= CH_IDLE;
         cnt     <= '0;
         pending <= RST_DIV;
         active  <= RST_DIV;
         out_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         pending <= pending_n;
         active  <= active_n;
         out_q   <= out_n;
         tick_q  <= tick_n;
      end
   end

   assign d_eff = eff_div(active);
   assign term  = (cnt == (d_eff - div_t'(1)));

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      pending_n = load ? ratio : pending;
      active_n  = active;
      out_n     = out_q;
      tick_n    = 1'b0;
      case (state)
         CH_IDLE: begin
            cnt_n = '0;
            out_n = 1'b0;
            if (load) active_n = ratio;
            if (ch_en) state_n = CH_RUN;
         end
         CH_RUN, CH_DRAIN: begin
            if ((state == CH_RUN) && !ch_en && !out_q) begin
               state_n = CH_IDLE;
               cnt_n   = '0;
            end else begin
               if ((state == CH_RUN) && !ch_en) state_n = CH_DRAIN;
               if (term) begin
                  cnt_n  = '0;
                  out_n  = ~out_q;
                  tick_n = ~out_q;
                  // Falling edge closes a full period: the only safe point to swap ratio.
                  if (out_q) begin
                     active_n = pending;
                     if (state_n == CH_DRAIN) state_n = CH_IDLE;
                  end
               end else begin
                  cnt_n = cnt + div_t'(1);
               end
            end
         end
         default: state_n = CH_IDLE;
      endcase
   end

   assign clk_out = out_q;
   assign tick    = tick_q;
   assign running = (state != CH_IDLE);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers running from clk_in.
// DIV_W must match the package ratio width; channels share only clock and reset.
module clk_div_bank
   import clk_buf_pkg::*;
#(
   parameter int               NUM_CH  = 4,
   parameter int               DIV_W   = DIV_W_DEF,
   parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(1)
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic [NUM_CH*DIV_W-1:0] div_ratio,
   input  logic [NUM_CH-1:0]       load,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       running
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_ch #(
         .RST_DIV (div_t'(RST_DIV))
      ) u_ch (
         .clk_in  (clk_in),
         .rst     (rst),
         .ch_en   (ch_en[i]),
         .load    (load[i]),
         .ratio   (div_ratio[i*DIV_W +: DIV_W]),
         .clk_out (clk_out[i]),
         .tick    (tick[i]),
         .running (running[i])
      );
   end

endmodule
